athena_rom_loader: RTL

ATHENA_ROM_LOADER -- requirements
Module: athena_rom_loader

---
 rtl/athena_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 87 ++++++++
 rtl/athena_rom_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/athena_pkg.sv
// -----------------------------------------------------------------------------
// athena_pkg
//   Shared definitions for the Athena ROM loader:
//     ROM_AW    - width of the byte address presented to the core ROM loader
//     IOCTL_DW  - width of the byte presented on ioctl_data
//     WORD_W    - width of an upstream word
//     state_e   - emitter FSM states
//     word_t    - one buffered word: its byte address plus its data
// -----------------------------------------------------------------------------
package athena_pkg;

  localparam int ROM_AW   = 25;
  localparam int IOCTL_DW = 8;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [WORD_W-1:0] data;
  } word_t;

endpackage : athena_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock first-in first-out buffer with registered full/empty flags.
//   The head entry is always visible on rdata_o; pop_i consumes it.
//
//   Parameters
//     WIDTH   - entry width in bits
//     DEPTH   - number of entries (power of two, >= 2)
//   Ports
//     clk     - clock
//     reset   - synchronous active-high reset, empties the buffer
//     push_i  - write wdata_i (ignored while full)
//     wdata_i - entry to write
//     pop_i   - consume the head entry (ignored while empty)
//     rdata_o - head entry
//     full_o  - registered: no free entries
//     empty_o - registered: no stored entries
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // NOTE: the storage array has no reset; the pointers and flags alone decide
  // what is valid, which lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule : sync_fifo

// File: rtl/athena_rom_loader.sv
// -----------------------------------------------------------------------------
// athena_rom_loader
//   Accepts 32-bit words with their byte address, buffers them, and replays
//   each word to the core ROM loader as four big-endian byte writes spaced
//   exactly PACE cycles apart (also across word boundaries while words are
//   queued). Misaligned words are accepted, dropped, and flagged.
//
//   Parameters
//     FIFO_DEPTH - words buffered (power of two, >= 2)
//     PACE       - cycles from one ioctl_wr pulse to the next (>= 2)
//   Ports
//     clk        - core clock, sole clock
//     reset      - synchronous active-high reset
//     wr_valid   - upstream word offered
//     wr_ready   - word accepted on the edge where wr_valid & wr_ready
//     wr_addr    - byte address of the word, bits [1:0] expected zero
//     wr_data    - word data, bits 31:24 emitted first
//     ioctl_addr - registered byte address to the core
//     ioctl_data - registered byte to the core
//     ioctl_wr   - one-cycle byte write strobe
//     busy       - words queued or a word is being emitted
//     align_err  - sticky: a misaligned word was received
// -----------------------------------------------------------------------------
module athena_rom_loader
  import athena_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PACE       = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ROM_AW-1:0]   wr_addr,
  input  logic [WORD_W-1:0]   wr_data,
  output logic [ROM_AW-1:0]   ioctl_addr,
  output logic [IOCTL_DW-1:0] ioctl_data,
  output logic                ioctl_wr,
  output logic                busy,
  output logic                align_err
);

  // The gap counter runs 0 .. PACE-2, so EMIT plus the gap spans PACE cycles.
  localparam int unsigned GAP_W = $clog2(PACE);

  word_t fifo_wdata;
  word_t head;
  logic  fifo_full;
  logic  fifo_empty;
  logic  push;
  logic  pop;
  logic  misaligned;

  state_e              state_q,      state_d;
  logic [1:0]          idx_q,        idx_d;
  logic [GAP_W-1:0]    gap_q,        gap_d;
  logic [ROM_AW-1:0]   word_addr_q,  word_addr_d;
  logic [WORD_W-1:0]   shift_q,      shift_d;
  logic [ROM_AW-1:0]   ioctl_addr_q, ioctl_addr_d;
  logic [IOCTL_DW-1:0] ioctl_data_q, ioctl_data_d;
  logic                ioctl_wr_q,   ioctl_wr_d;
  logic                align_err_q;
  logic                load;

  // wr_ready depends only on registered state and reset, never on wr_valid.
  assign wr_ready   = ~fifo_full & ~reset;
  assign misaligned = |wr_addr[1:0];
  assign push       = wr_valid & wr_ready & ~misaligned;
  assign fifo_wdata = '{addr: wr_addr, data: wr_data};

  sync_fifo #(
    .WIDTH ($bits(word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    word_addr_d  = word_addr_q;
    shift_d      = shift_q;
    ioctl_addr_d = ioctl_addr_q;
    ioctl_data_d = ioctl_data_q;
    ioctl_wr_d   = 1'b0;
    load         = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end

      EMIT: begin
        // Outputs are registered, so the strobe appears the cycle after EMIT.
        ioctl_wr_d   = 1'b1;
        ioctl_addr_d = word_addr_q + ROM_AW'(idx_q);
        ioctl_data_d = shift_q[WORD_W-1 -: IOCTL_DW];
        shift_d      = {shift_q[WORD_W-IOCTL_DW-1:0], {IOCTL_DW{1'b0}}};
        gap_d        = '0;
        state_d      = GAP;
      end

      GAP: begin
        if (gap_q == GAP_W'(PACE - 2)) begin
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = EMIT;
          end else if (!fifo_empty) begin
            // Chain straight into the next word to keep the PACE spacing.
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (load) begin
      pop         = 1'b1;
      word_addr_d = head.addr;
      shift_d     = head.data;
      idx_d       = 2'd0;
      state_d     = EMIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      word_addr_q  <= '0;
      shift_q      <= '0;
      ioctl_addr_q <= '0;
      ioctl_data_q <= '0;
      ioctl_wr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      word_addr_q  <= word_addr_d;
      shift_q      <= shift_d;
      ioctl_addr_q <= ioctl_addr_d;
      ioctl_data_q <= ioctl_data_d;
      ioctl_wr_q   <= ioctl_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      align_err_q <= 1'b0;
    end else if (wr_valid && wr_ready && misaligned) begin
      align_err_q <= 1'b1;
    end
  end

  assign ioctl_addr = ioctl_addr_q;
  assign ioctl_data = ioctl_data_q;
  assign ioctl_wr   = ioctl_wr_q;
  assign align_err  = align_err_q;
  assign busy       = ~reset & ((state_q != IDLE) | ~fifo_empty);

endmodule : athena_rom_loader
